// File: rtl/player_cannon_ctrl.sv
// player_cannon_ctrl: moves the player cannon with per-frame acceleration,
// runs the alive/explode/respawn/game-over life cycle, paces fire pulses for
// the bullet spawner and renders the cannon pixel for the VGA mixer.
module player_cannon_ctrl #(
  parameter int SPRITE_W       = 16,
  parameter int SPRITE_H       = 16,
  parameter int SHIP_Y         = 440,
  parameter int SCREEN_W       = 640,
  parameter int START_X        = 312,
  parameter int MAX_SPEED      = 4,
  parameter int ACCEL_FRAMES   = 2,
  parameter int EXPLODE_FRAMES = 32,
  parameter int BLINK_FRAMES   = 64,
  parameter int LIVES          = 3,
  parameter int FIRE_COOLDOWN  = 16,
  // Name of the external sprite image; the sprite rows themselves are
  // generated by rom_row() below so the block elaborates without the file.
  parameter     ROM_FILE       = "src/rtl/cannon_frames.hex"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_sync,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       fire,
  input  logic       hit,
  input  logic [1:0] scale_log2,
  output logic [9:0] cannon_x_pos,
  output logic       fire_pulse,
  output logic [2:0] lives_left,
  output logic       vulnerable,
  output logic       game_over,
  output logic       cannon_graphics
);

  localparam int VW   = $clog2(MAX_SPEED + 1);
  localparam int AW   = $clog2(ACCEL_FRAMES + 1);
  localparam int CW   = $clog2(FIRE_COOLDOWN + 1);
  localparam int FMAX = (EXPLODE_FRAMES > BLINK_FRAMES) ? EXPLODE_FRAMES : BLINK_FRAMES;
  // frame_cnt needs bit 2 for the blink even with tiny frame counts
  localparam int FW   = ($clog2(FMAX) < 3) ? 3 : $clog2(FMAX);
  localparam int CLW  = $clog2(SPRITE_W);
  localparam int RW   = $clog2(2 * SPRITE_H);

  localparam logic [VW-1:0] VEL_MAX    = VW'(MAX_SPEED);
  localparam logic [AW-1:0] ACC_MAX    = AW'(ACCEL_FRAMES);
  localparam logic [CW-1:0] CD_INIT    = CW'(FIRE_COOLDOWN);
  localparam logic [FW-1:0] EXP_LAST   = FW'(EXPLODE_FRAMES - 1);
  localparam logic [FW-1:0] BLK_LAST   = FW'(BLINK_FRAMES - 1);
  localparam logic [9:0]    X_START    = 10'(START_X);
  localparam logic [9:0]    Y_TOP      = 10'(SHIP_Y);
  localparam logic [9:0]    SCR_W      = 10'(SCREEN_W);
  localparam logic [9:0]    SPR_W      = 10'(SPRITE_W);
  localparam logic [9:0]    SPR_H      = 10'(SPRITE_H);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
  localparam logic [RW-1:0] EXP_ROW    = RW'(SPRITE_H);

  typedef enum logic [1:0] {S_ALIVE, S_EXPLODE, S_RESPAWN, S_GAME_OVER} state_t;
  typedef enum logic [1:0] {D_NONE, D_LEFT, D_RIGHT} dir_t;

  // Sprite image: rows 0..SPRITE_H-1 are the cannon (a widening wedge),
  // rows SPRITE_H.. are the explosion frame (diagonal debris). Column c
  // lives in bit SPRITE_W-1-c.
  function automatic logic [SPRITE_W-1:0] rom_row(input int r);
    logic [SPRITE_W-1:0] v;
    v = '0;
    for (int c = 0; c < SPRITE_W; c++) begin
      if (r < SPRITE_H)
        v[SPRITE_W-1-c] = (c >= SPRITE_W/2 - 1 - r/2) && (c <= SPRITE_W/2 + r/2);
      else
        v[SPRITE_W-1-c] = ((r + c) % 3) == 0;
    end
    return v;
  endfunction

  state_t        state, state_n;
  dir_t          dir, dir_q, dir_n;
  logic          v_sync_q, tick, hit_pending, hit_now, run, fire_go;
  logic [9:0]    x, x_n, max_x;
  logic [VW-1:0] vel, vel_n;
  logic [AW-1:0] acc, acc_n;
  logic [CW-1:0] cd, cd_n;
  logic [FW-1:0] fc, fc_n;
  logic [2:0]    lives, lives_n;

  assign tick    = v_sync & ~v_sync_q;
  assign hit_now = hit_pending | hit;
  assign dir     = (move_left & ~move_right) ? D_LEFT :
                   (move_right & ~move_left) ? D_RIGHT : D_NONE;
  assign max_x   = SCR_W - (SPR_W << scale_log2);

  assign cannon_x_pos = x;
  assign lives_left   = lives;
  assign vulnerable   = (state == S_ALIVE);
  assign game_over    = (state == S_GAME_OVER);

  // Next frame's state, motion, cooldown and life count (applied only on a tick)
  always_comb begin
    state_n = state;
    x_n     = x;
    vel_n   = vel;
    acc_n   = acc;
    dir_n   = dir_q;
    cd_n    = cd;
    fc_n    = fc;
    lives_n = lives;
    fire_go = 1'b0;
    run     = 1'b0;
    unique case (state)
      S_ALIVE: begin
        if (hit_now) begin
          state_n = S_EXPLODE;
          lives_n = lives - 3'd1;
          vel_n   = '0;
          acc_n   = '0;
          dir_n   = D_NONE;
          fc_n    = '0;
        end else begin
          run = 1'b1;
        end
      end
      S_EXPLODE: begin
        if (fc == EXP_LAST) begin
          fc_n = '0;
          if (lives == 3'd0) begin
            state_n = S_GAME_OVER;
          end else begin
            state_n = S_RESPAWN;
            x_n     = X_START;
          end
        end else begin
          fc_n = fc + 1'b1;
        end
      end
      S_RESPAWN: begin
        run = 1'b1;
        if (fc == BLK_LAST) begin
          state_n = S_ALIVE;
          fc_n    = '0;
        end else begin
          fc_n = fc + 1'b1;
        end
      end
      default: ;
    endcase

    if (run) begin
      // Speed ramps one step every ACCEL_FRAMES frames of a steady direction
      if (dir == D_NONE) begin
        vel_n = '0;
        acc_n = '0;
      end else if (dir != dir_q) begin
        vel_n = VW'(1);
        acc_n = AW'(1);
      end else if (acc == ACC_MAX && vel < VEL_MAX) begin
        vel_n = vel + 1'b1;
        acc_n = AW'(1);
      end else if (acc != ACC_MAX) begin
        acc_n = acc + 1'b1;
      end
      dir_n = dir;

      if (dir == D_LEFT)
        x_n = (x >= 10'(vel_n)) ? x - 10'(vel_n) : '0;
      else if (dir == D_RIGHT)
        x_n = (x + 10'(vel_n) > max_x) ? max_x : x + 10'(vel_n);
      // a larger scale can leave the cannon hanging off the right edge
      if (x_n > max_x) x_n = max_x;

      if (cd == '0 && fire) begin
        fire_go = 1'b1;
        cd_n    = CD_INIT;
      end else if (cd != '0) begin
        cd_n = cd - 1'b1;
      end
    end
  end

  // State and datapath registers; hits between frames are latched until the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ALIVE;
      v_sync_q    <= 1'b1;
      hit_pending <= 1'b0;
      x           <= X_START;
      vel         <= '0;
      acc         <= '0;
      dir_q       <= D_NONE;
      cd          <= '0;
      fc          <= '0;
      lives       <= LIVES_INIT;
      fire_pulse  <= 1'b0;
    end else begin
      v_sync_q   <= v_sync;
      fire_pulse <= tick & fire_go;
      if (tick) begin
        hit_pending <= 1'b0;
        state       <= state_n;
        x           <= x_n;
        vel         <= vel_n;
        acc         <= acc_n;
        dir_q       <= dir_n;
        cd          <= cd_n;
        fc          <= fc_n;
        lives       <= lives_n;
      end else if (hit) begin
        hit_pending <= 1'b1;
      end
    end
  end

  logic [10:0]         x_end, y_end;
  logic [CLW-1:0]      col;
  logic [RW-1:0]       rom_r;
  logic [SPRITE_W-1:0] row_bits;
  logic                in_b, lit;

  // Pixel-on for the mixer: scaled sprite lookup, blanked in game over and blink phases
  always_comb begin
    x_end    = {1'b0, x} + ({1'b0, SPR_W} << scale_log2);
    y_end    = {1'b0, Y_TOP} + ({1'b0, SPR_H} << scale_log2);
    in_b     = (pix_x >= x) && ({1'b0, pix_x} < x_end) &&
               (pix_y >= Y_TOP) && ({1'b0, pix_y} < y_end);
    col      = CLW'((pix_x - x) >> scale_log2);
    rom_r    = RW'((pix_y - Y_TOP) >> scale_log2) + ((state == S_EXPLODE) ? EXP_ROW : '0);
    row_bits = rom_row(int'(rom_r));
    lit      = row_bits[CLW'(SPRITE_W - 1) - col];
    cannon_graphics = in_b && lit && (state != S_GAME_OVER) &&
                      !((state == S_RESPAWN) && fc[2]);
  end

endmodule
